seq_divider_ctrl: RTL and testbench
===================================

// Module: seq_divider_ctrl
// PURPOSE
//  Multi-cycle unsigned restoring divider for the CPU execute stage. Produces
//  one quotient bit per clock over a shared shift/subtract datapath. Accepts
//  one operation at a time via start/busy/done handshake. Flags divide-by-zero.
//  Sits beside the ALU; the decoder stalls issue while busy_o is high.
// PARAMETERS
//  N    16   operand width: dividend, divisor, quotient and remainder in bits
//  CW   $clog2(N+1)  iteration counter width (derived; do not override)
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  start_i     in   1   request; sampled only in IDLE
//  clear_i     in   1   synchronous abort; returns to IDLE, outputs hold
//  dividend_i  in   N   numerator, captured on accepted start
//  divisor_i   in   N   denominator, captured on accepted start
//  busy_o      out  1   high in RUN and DONE states
//  done_o      out  1   one-cycle pulse; quotient/remainder valid
//  dz_o        out  1   divide-by-zero flag of last op, held until next start
//  quotient_o  out  N   result, held until next accepted start
//  remainder_o out  N   result, held until next accepted start
// BEHAVIOUR
//  Reset (rst_n=0, any time incl. mid-op): state=IDLE, busy_o=0, done_o=0,
//   dz_o=0, quotient_o=0, remainder_o=0, counter=0, internal regs=0.
//  States: IDLE -> RUN -> DONE -> IDLE; IDLE -> DONE on divide-by-zero.
//  IDLE: start_i=1 at edge T0 captures operands. divisor_i!=0 -> RUN,
//   Q=dividend, R=0 (N+1 bits), cnt=0, dz_o cleared. divisor_i==0 -> DONE,
//   dz_o=1, quotient_o={N{1'b1}}, remainder_o=dividend_i.
//  RUN, per cycle: {R,Q} <<= 1; T = R - {1'b0,divisor};
//   T>=0 (MSB 0): R=T, Q[0]=1; else R kept, Q[0]=0. cnt++.
//   After the N-th RUN cycle (cnt==N-1 at edge) -> DONE; quotient_o=Q,
//   remainder_o=R[N-1:0] loaded on that same edge.
//  DONE: done_o=1 for exactly one cycle, then IDLE.
//  Latency: normal op done_o high in cycle T0+N+1 (17 clocks for N=16);
//   divide-by-zero done_o high in cycle T0+1.
//  start_i in RUN or DONE: ignored, no capture, no queueing.
//  clear_i: priority over start_i and RUN progress; next state IDLE, done_o
//   not asserted, quotient_o/remainder_o/dz_o retain prior values.
//  Invariant: done_o implies busy_o; busy_o=0 only in IDLE.
//  Result holds: dividend = quotient*divisor + remainder, remainder < divisor.
//  Outputs registered; no combinational path input->output.
// TESTING (N=16)
//  1) 100/7 start at T0 -> busy_o=1 T0+1..T0+17, done_o @T0+17, q=14, r=2, dz=0.
//  2) 0xFFFF/1 -> q=0xFFFF, r=0; 3/10 -> q=0, r=3; 0xFFFF/0xFFFF -> q=1, r=0.
//  3) 5/0 -> done_o @T0+1, dz_o=1, q=0xFFFF, r=5; next 9/3 clears dz_o, q=3.
//  4) start_i pulsed at T0+5 during 100/7 with 8/2 -> ignored, result q=14 r=2.
//  5) rst_n low at T0+8 mid-op -> all outputs 0 immediately; new 8/2 -> q=4 r=0.
//  6) clear_i at T0+6 -> IDLE, no done_o, previous q/r held; 200/9 -> q=22 r=2.

Source files
------------

// File: rtl/seq_divider_ctrl.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Latency N+1 cycles to done_o (1 on divide-by-zero); start_i is ignored while busy_o is high.
module seq_divider_ctrl #(
   parameter  int N  = 16,
   localparam int CW = $clog2(N+1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic         clear_i,
   input  logic [N-1:0] dividend_i,
   input  logic [N-1:0] divisor_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         dz_o,
   output logic [N-1:0] quotient_o,
   output logic [N-1:0] remainder_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_q;
   logic [N:0]    r_r;
   logic [N-1:0]  r_div;
   logic [N-1:0]  r_quot;
   logic [N-1:0]  r_rem;
   logic          r_dz;

   logic [N:0]    w_r_sh;
   logic [N:0]    w_t;
   logic [N:0]    w_r_nxt;
   logic [N-1:0]  w_q_nxt;
   logic          w_last;

   // Partial remainder stays below the divisor, so N+1 bits hold the trial difference and its sign.
   assign w_r_sh  = {r_r[N-1:0], r_q[N-1]};
   assign w_t     = w_r_sh - {1'b0, r_div};
   assign w_r_nxt = w_t[N] ? w_r_sh : w_t;
   assign w_q_nxt = {r_q[N-2:0], ~w_t[N]};
   assign w_last  = (r_cnt == CW'(N-1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (start_i) w_state_nxt = (divisor_i == '0) ? S_DONE : S_RUN;
         S_RUN:  if (w_last)  w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (clear_i) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_q    <= '0;
         r_r    <= '0;
         r_div  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dz   <= 1'b0;
      end else if (!clear_i) begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_div <= divisor_i;
                  if (divisor_i == '0) begin
                     r_dz   <= 1'b1;
                     r_quot <= '1;
                     r_rem  <= dividend_i;
                  end else begin
                     r_dz  <= 1'b0;
                     r_q   <= dividend_i;
                     r_r   <= '0;
                     r_cnt <= '0;
                  end
               end
            end
            S_RUN: begin
               r_r   <= w_r_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_quot <= w_q_nxt;
                  r_rem  <= w_r_nxt[N-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = (r_state == S_DONE);
   assign dz_o        = r_dz;
   assign quotient_o  = r_quot;
   assign remainder_o = r_rem;

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Directed bench for seq_divider_ctrl (N=16): latency, results, divide-by-zero, ignored start, reset and clear.
module tb_seq_divider_ctrl;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0;
   logic         clear_i = 1'b0;
   logic [N-1:0] dividend_i = '0;
   logic [N-1:0] divisor_i = '0;
   logic         busy_o;
   logic         done_o;
   logic         dz_o;
   logic [N-1:0] quotient_o;
   logic [N-1:0] remainder_o;

   int n_err = 0;
   int n_chk = 0;

   seq_divider_ctrl #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
      .dividend_i(dividend_i), .divisor_i(divisor_i),
      .busy_o(busy_o), .done_o(done_o), .dz_o(dz_o),
      .quotient_o(quotient_o), .remainder_o(remainder_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of cycle T0+1.
   task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
      start_i = 1'b1; dividend_i = a; divisor_i = b;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Starting at cycle T0+k0, scans for done_o; lat=0 on timeout.
   task automatic wait_done(input int k0, output int lat, output bit busy_ok);
      lat = 0; busy_ok = 1'b1;
      for (int k = k0; k <= 40; k++) begin
         if (!busy_o) busy_ok = 1'b0;
         if (done_o) begin lat = k; break; end
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int exp_lat, input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic edz);
      int lat; bit busy_ok;
      launch(a, b);
      check({tag, "_dz_early"}, dz_o, edz);
      wait_done(1, lat, busy_ok);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy"}, busy_ok, 1'b1);
      check({tag, "_q"}, quotient_o, eq);
      check({tag, "_r"}, remainder_o, er);
      check({tag, "_dz"}, dz_o, edz);
      @(negedge clk);
      check({tag, "_idle"}, {busy_o, done_o}, 2'b00);
   endtask

   initial begin
      int lat; bit busy_ok; int done_cnt;
      repeat (2) @(negedge clk);
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_dz", dz_o, 1'b0);
      check("rst_q", quotient_o, 16'h0);
      check("rst_r", remainder_o, 16'h0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("d100_7",  16'd100,  16'd7,    17, 16'd14,   16'd2, 1'b0);
      run_op("dffff_1", 16'hFFFF, 16'd1,    17, 16'hFFFF, 16'd0, 1'b0);
      run_op("d3_10",   16'd3,    16'd10,   17, 16'd0,    16'd3, 1'b0);
      run_op("dffff_ff",16'hFFFF, 16'hFFFF, 17, 16'd1,    16'd0, 1'b0);
      run_op("dz5",     16'd5,    16'd0,    1,  16'hFFFF, 16'd5, 1'b1);
      run_op("d9_3",    16'd9,    16'd3,    17, 16'd3,    16'd0, 1'b0);

      // start pulse during RUN must be ignored
      launch(16'd100, 16'd7);
      repeat (4) @(negedge clk);
      start_i = 1'b1; dividend_i = 16'd8; divisor_i = 16'd2;
      @(negedge clk);
      start_i = 1'b0;
      wait_done(6, lat, busy_ok);
      check("ign_latency", lat, 17);
      check("ign_q", quotient_o, 16'd14);
      check("ign_r", remainder_o, 16'd2);
      repeat (2) @(negedge clk);
      check("ign_noqueue", busy_o, 1'b0);

      // asynchronous reset mid-operation
      launch(16'd1000, 16'd33);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy_o, 1'b0);
      check("arst_q", quotient_o, 16'h0);
      check("arst_r", remainder_o, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("d8_2", 16'd8, 16'd2, 17, 16'd4, 16'd0, 1'b0);

      // synchronous clear mid-operation
      launch(16'd1000, 16'd33);
      repeat (5) @(negedge clk);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      check("clr_busy", busy_o, 1'b0);
      done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (done_o || busy_o) done_cnt++;
         @(negedge clk);
      end
      check("clr_no_done", done_cnt, 0);
      check("clr_q_hold", quotient_o, 16'd4);
      check("clr_r_hold", remainder_o, 16'd0);
      run_op("d200_9", 16'd200, 16'd9, 17, 16'd22, 16'd2, 1'b0);

      // clear wins over start in IDLE
      clear_i = 1'b1; start_i = 1'b1; dividend_i = 16'd50; divisor_i = 16'd0;
      @(negedge clk);
      clear_i = 1'b0; start_i = 1'b0;
      check("clr_start_busy", busy_o, 1'b0);
      check("clr_start_dz", dz_o, 1'b0);
      run_op("d1000_33", 16'd1000, 16'd33, 17, 16'd30, 16'd10, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
